imem_responder: RTL

Instruction-memory responder for the RISC-V CPU: it answers the core's instruction fetch address (`iaddr`) with a 32-bit instruction word (`idata`) after a fixed, parameterised latency. Storage is word-addressed and filled through a separate load port by the testbench or boot logic. After reset the block clears every word to the canonical NOP. It sits between the CPU fetch stage and the program image, replacing the ad-hoc instruction array that benches currently hold.

---
 rtl/imem_responder.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/imem_responder.sv
// imem_responder
//   Instruction-memory responder for the CPU fetch stage. Answers a byte
//   fetch address with a 32-bit instruction word after a fixed LATENCY.
//   Storage is word-addressed, cleared to NOP after reset by a CLEAR
//   sequence, and written through a separate load port.
//
// State   | meaning
// --------+-------------------------------------------------------------
// CLEAR   | writing NOP to word ptr each cycle, fetch and load blocked
// SERVE   | serving fetches; a load takes priority over a fetch
//
// Ports
//   clk, reset              rising-edge clock, synchronous active-high reset
//   req_valid, iaddr        fetch request and its byte address
//   req_ready               fetch accepted on req_valid & req_ready
//   resp_valid, idata       response strobe and fetched word (idata holds)
//   resp_err                misaligned or out-of-range fetch (idata = NOP)
//   load_en, load_addr,     storage write port (word index / data)
//   load_data
//   load_ack                one-cycle pulse the cycle after a write
//   busy                    clear sequence in progress
module imem_responder #(
    parameter int          DEPTH   = 16,
    parameter int          LATENCY = 1,
    parameter logic [31:0] NOP     = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    input  logic [31:0]              iaddr,
    output logic                     req_ready,
    output logic                     resp_valid,
    output logic [31:0]              idata,
    output logic                     resp_err,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [31:0]              load_data,
    output logic                     load_ack,
    output logic                     busy
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {CLEAR, SERVE} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic [31:0]     mem_q [DEPTH];

    logic [LATENCY-1:0] vld_q;
    logic [LATENCY-1:0] err_q;
    logic [31:0]        dat_q [LATENCY];
    logic               load_ack_q;

    logic          accept;
    logic          addr_err;
    logic [AW-1:0] rd_idx;
    logic [31:0]   rd_word;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        busy      = 1'b0;
        req_ready = 1'b0;
        case (state_q)
            CLEAR: begin
                busy  = 1'b1;
                ptr_d = ptr_q + AW'(1);
                if (ptr_q == AW'(DEPTH - 1)) begin
                    state_d = SERVE;
                    ptr_d   = '0;
                end
            end
            SERVE: begin
                // a pending load wins the storage port this cycle
                req_ready = ~load_en;
            end
            default: begin
                state_d = CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Fetch decode; erroneous fetches never touch storage.
    assign accept   = req_valid & req_ready;
    assign addr_err = (iaddr[1:0] != 2'b00) | (|iaddr[31:AW+2]);
    assign rd_idx   = iaddr[AW+1:2];
    assign rd_word  = addr_err ? NOP : mem_q[rd_idx];

    // Contents are not reset directly; the CLEAR sequence rewrites them.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == CLEAR) begin
                mem_q[ptr_q] <= NOP;
            end else if (load_en) begin
                mem_q[load_addr] <= load_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            load_ack_q <= 1'b0;
        end else begin
            load_ack_q <= load_en & (state_q == SERVE);
        end
    end

    // Response pipeline: stage 0 captures at acceptance, data/err only
    // advance with a valid token so the last stage holds its value.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            err_q <= '0;
            for (int s = 0; s < LATENCY; s++) begin
                dat_q[s] <= NOP;
            end
        end else begin
            vld_q[0] <= accept;
            if (accept) begin
                dat_q[0] <= rd_word;
                err_q[0] <= addr_err;
            end
            for (int s = 1; s < LATENCY; s++) begin
                vld_q[s] <= vld_q[s-1];
                if (vld_q[s-1]) begin
                    dat_q[s] <= dat_q[s-1];
                    err_q[s] <= err_q[s-1];
                end
            end
        end
    end

    assign resp_valid = vld_q[LATENCY-1];
    assign idata      = dat_q[LATENCY-1];
    assign resp_err   = err_q[LATENCY-1] & vld_q[LATENCY-1];
    assign load_ack   = load_ack_q;

endmodule
